cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run controller that sequences the CPU from the board clock. It replaces the free-running clock divider with a single-cycle clock enable `cpu_ce` in three modes:
- free-run at a selectable rate;
- debounced single-step from a push button;
- halted on CPU `halt`.

It sits in `fpga_top` between the board clock/switches and the `cpu` instance, and exposes a saturating executed-cycle counter for display on the port LEDs.

## Interface
- `DIV_WIDTH`, default 8: width of the rate-select input and of the internal divider counter.
- `DEBOUNCE_CYCLES`, default 16'd50000: number of consecutive stable synchronized samples needed to accept a new button level.
- `CNT_WIDTH`, default 32: width of the executed-cycle counter.

Ports:
- `clk`, input, 1: board clock; the only clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `run_en`, input, 1: asynchronous switch; 1 = free-run, 0 = stopped/step mode.
- `step_btn`, input, 1: asynchronous push button, active-high.
- `div_sel`, input, `DIV_WIDTH`: in RUN, `cpu_ce` fires once every `div_sel`+1 clocks.
- `halt`, input, 1: CPU halt flag, synchronous to `clk`.
- `cpu_ce`, output, 1: one-cycle CPU clock enable; registered.
- `state`, output, 2: current `run_state_t`.
- `cycle_count`, output, `CNT_WIDTH`: number of `cpu_ce` pulses issued; saturating.

## Operation
Reset (async, `rst`=1): state=ST_STOPPED, `cpu_ce`=0, `cycle_count`=0, divider=0, synchronizers and debouncer cleared with accepted level 0.

Input conditioning:
- `run_en` passes through a 2-FF synchronizer.
- `step_btn` passes through a 2-FF synchronizer and then the debouncer.
- The debouncer changes its accepted level only after `DEBOUNCE_CYCLES` consecutive samples differ from the current level. Any bounce restarts the count.
- A rising edge of the accepted level produces a one-cycle `step_pulse`.

States:
- ST_STOPPED:
  - Synchronized `run_en`=1 → ST_RUN, divider cleared.
  - Otherwise, `step_pulse` && !`halt` → `cpu_ce`=1 on the next clock; state stays ST_STOPPED.
- ST_RUN:
  - The divider counts 0..`div_sel`.
  - When divider >= `div_sel`: divider wraps to 0, and if !`halt`, `cpu_ce`=1 on the next clock.
  - The >= compare makes a mid-count decrease of `div_sel` wrap immediately.
  - Synchronized `run_en`=0 → ST_STOPPED, divider cleared, no `cpu_ce` issued.
  - `halt`=1 → ST_HALTED.
- ST_HALTED: terminal. `cpu_ce` is held 0, and `step_pulse`, `run_en` and `div_sel` are ignored. Only `rst` exits this state.
- `halt`=1 sampled in ST_STOPPED also → ST_HALTED.

Other rules:
- A `step_pulse` arriving in ST_RUN is discarded and is not queued.
- `cycle_count` increments on every clock in which `cpu_ce`=1 and holds at all-ones.
- `div_sel`=0 gives continuous `cpu_ce`. `div_sel`=1 gives one pulse every 2 clocks, which is the legacy /2 rate.

## Timing
- `cpu_ce` comes from a flop: `ce_d` is computed from the current state, divider, `step_pulse` and `halt`, and registered at the clock edge.
- When `halt`=1 at edge k, `cpu_ce` is 0 from edge k onward and state=ST_HALTED after edge k. No further pulses follow.
- Step latency is `DEBOUNCE_CYCLES`+3 clocks from the first edge that samples `step_btn`=1 (after which it stays stable) to `cpu_ce`=1:
  - 2 synchronizer stages;
  - `DEBOUNCE_CYCLES` of stable samples;
  - 1 cycle to form `step_pulse`.
- Exactly one `cpu_ce` per press, regardless of hold time. Release is debounced with the same rule and produces no pulse.
- `run_en` 0→1 latency: ST_RUN 3 clocks after the edge, first `cpu_ce` `div_sel`+1 clocks later.
- A mid-operation `rst` drops `cpu_ce` asynchronously; the counter is lost.

## Structure
- Package `run_ctrl_pkg` holds:
  - `typedef enum logic [1:0] run_state_t` with ST_STOPPED=0, ST_RUN=1, ST_HALTED=2;
  - the default constant `DEBOUNCE_DEFAULT`.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `btn_in`, `level`, `rise_pulse`) contains the 2-FF synchronizer, the stability counter and the edge detector. It is instantiated once, for `step_btn`.
- `fpga_top` drives `cpu` on `clk` with `cpu_ce`, `sw` bits map to `run_en`/`div_sel`, and `cycle_count[15:0]` is selectable on `led`.

## Test plan
All benches use `DEBOUNCE_CYCLES`=4.
- **Reset:** assert `rst` mid-RUN with `div_sel`=0 → `cpu_ce`=0 immediately, `state`=0, `cycle_count`=0, held until release.
- **Free-run rate:** `run_en`=1, `div_sel`=3, 40 clocks after entering ST_RUN → `cpu_ce` pulses exactly every 4 clocks, `cycle_count`=10. Switch to `div_sel`=0 → `cpu_ce` is continuous.
- **Step with bounce:** `run_en`=0; `step_btn` toggles 1,0,1, then holds 1 for 20 clocks, then releases → exactly one `cpu_ce`, 7 clocks after the stable rise; `cycle_count`=1.
- **Halt:** in RUN with `div_sel`=0, raise `halt` at edge k →
  - last pulse is at edge k-1;
  - `state`=2 from edge k;
  - subsequent steps and `run_en` toggles produce no pulses.
- **Mode switch:** `run_en` 1→0 mid-count with `div_sel`=5 → no stray `cpu_ce`, `state`=0. A step pressed while in RUN produces no pulse after returning to STOPPED.
- **Saturation:** `CNT_WIDTH`=4 with continuous run → `cycle_count` holds at 15 and does not wrap.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the CPU run controller.
// The FSM state encoding is visible on the top-level state port.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2
    } run_state_t;

    localparam logic [15:0] DEBOUNCE_DEFAULT = 16'd50000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability-count debouncer
// and a registered rising-edge pulse of the accepted level.
module btn_debounce
    import run_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse
);

    localparam logic [15:0] LAST_SAMPLE = DEBOUNCE_CYCLES - 16'd1;

    logic        sync1;
    logic        sync2;
    logic        level_prev;
    logic [15:0] stable_cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample;
    // any sample equal to the current level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            rise_pulse <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1      <= btn_in;
            sync2      <= sync1;
            level_prev <= level;
            rise_pulse <= level & ~level_prev;
            if (sync2 != level) begin
                if (stable_cnt == LAST_SAMPLE) begin
                    level      <= sync2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 16'd1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: issues a registered one-cycle clock enable in
// free-run, single-step or halted mode and counts the enables issued.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned DIV_WIDTH       = 8,
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_en,
    input  logic                 step_btn,
    input  logic [DIV_WIDTH-1:0] div_sel,
    input  logic                 halt,
    output logic                 cpu_ce,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    run_state_t           state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 ce_d;
    logic                 run_s1, run_s2;
    logic                 btn_level;
    logic                 step_pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (step_btn),
        .level      (btn_level),
        .rise_pulse (step_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_s1      <= 1'b0;
            run_s2      <= 1'b0;
            state_q     <= ST_STOPPED;
            div_q       <= '0;
            cpu_ce      <= 1'b0;
            cycle_count <= '0;
        end else begin
            run_s1  <= run_en;
            run_s2  <= run_s1;
            state_q <= state_d;
            div_q   <= div_d;
            cpu_ce  <= ce_d;
            if (cpu_ce && (cycle_count != '1))
                cycle_count <= cycle_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ce_d    = 1'b0;
        unique case (state_q)
            ST_STOPPED: begin
                div_d = '0;
                if (halt)
                    state_d = ST_HALTED;
                else if (run_s2)
                    state_d = ST_RUN;
                else if (step_pulse && btn_level)
                    ce_d = 1'b1;
            end
            ST_RUN: begin
                // >= lets a lowered div_sel wrap at once instead of counting past it
                if (halt) begin
                    state_d = ST_HALTED;
                    div_d   = '0;
                end else if (!run_s2) begin
                    state_d = ST_STOPPED;
                    div_d   = '0;
                end else if (div_q >= div_sel) begin
                    div_d = '0;
                    ce_d  = 1'b1;
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
            ST_HALTED: begin
                div_d = '0;
            end
            default: begin
                state_d = ST_STOPPED;
                div_d   = '0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected cpu_ce edge numbers are queued
// as stimulus is applied and matched against each observed pulse.
module tb_cpu_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          run_en;
    logic          step_btn;
    logic          halt;
    logic [DW-1:0] div_sel;
    logic          cpu_ce;
    logic [1:0]    state;
    logic [31:0]   cycle_count;
    logic          sat_ce;
    logic [1:0]    sat_state;
    logic [3:0]    sat_count;

    int unsigned cyc = 0;
    int unsigned exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned e;

    cpu_run_ctrl #(
        .DIV_WIDTH       (DW),
        .DEBOUNCE_CYCLES (16'd4),
        .CNT_WIDTH       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .step_btn    (step_btn),
        .div_sel     (div_sel),
        .halt        (halt),
        .cpu_ce      (cpu_ce),
        .state       (state),
        .cycle_count (cycle_count)
    );

    cpu_run_ctrl #(
        .DIV_WIDTH       (DW),
        .DEBOUNCE_CYCLES (16'd4),
        .CNT_WIDTH       (4)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .step_btn    (step_btn),
        .div_sel     (div_sel),
        .halt        (halt),
        .cpu_ce      (sat_ce),
        .state       (sat_state),
        .cycle_count (sat_count)
    );

    always #5 clk = ~clk;

    // After the posedge numbered n, cyc reads n at the following negedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, output int unsigned at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state !== s && n < 20);
        check("wait_state", state, s);
        at = cyc;
    endtask

    always @(negedge clk) begin
        if (!rst && cpu_ce) begin
            if (exp_q.size() == 0)
                check("ce_stray", cpu_ce, 0);
            else
                check("ce_time", cyc, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; run_en = 1'b0; step_btn = 1'b0; halt = 1'b0; div_sel = '0;
        #1 rst = 1'b1;
        tick(3);
        check("rst_state", state, 0);
        check("rst_ce", cpu_ce, 0);
        check("rst_cnt", cycle_count, 0);
        rst = 1'b0;

        // asynchronous reset in the middle of continuous run
        run_en = 1'b1; div_sel = 8'd0;
        wait_state(2'd1, e);
        for (int i = 1; i <= 5; i++) exp_q.push_back(e + i);
        tick(5);
        #1 rst = 1'b1;
        #1;
        check("rst_async_ce", cpu_ce, 0);
        check("rst_async_state", state, 0);
        check("rst_async_cnt", cycle_count, 0);
        tick(3);
        check("rst_hold_ce", cpu_ce, 0);
        check("rst_hold_cnt", cycle_count, 0);
        run_en = 1'b0;
        rst = 1'b0;
        check("rst_q_empty", exp_q.size(), 0);

        // free run at /4, then continuous, then stop
        div_sel = 8'd3; run_en = 1'b1;
        wait_state(2'd1, e);
        for (int i = 1; i <= 10; i++) exp_q.push_back(e + 4 * i);
        tick(41);
        check("run_cnt10", cycle_count, 10);
        div_sel = 8'd0;
        for (int unsigned c = e + 42; c <= e + 63; c++) exp_q.push_back(c);
        tick(20);
        check("sat_cnt_run", sat_count, 15);
        run_en = 1'b0;
        tick(4);
        check("run_stop_state", state, 0);
        check("run_cnt32", cycle_count, 32);
        check("run_q_empty", exp_q.size(), 0);
        check("sat_cnt_hold", sat_count, 15);

        // single step with a bouncing press
        step_btn = 1'b1; tick(1);
        step_btn = 1'b0; tick(1);
        step_btn = 1'b1;
        exp_q.push_back(cyc + 8);
        tick(20);
        step_btn = 1'b0;
        tick(20);
        check("step_q_empty", exp_q.size(), 0);
        check("step_cnt", cycle_count, 33);
        check("step_state", state, 0);

        // leave RUN mid-count, with a step pressed while running
        div_sel = 8'd5; run_en = 1'b1;
        wait_state(2'd1, e);
        exp_q.push_back(e + 6);
        step_btn = 1'b1;
        tick(8);
        run_en = 1'b0;
        tick(10);
        step_btn = 1'b0;
        tick(10);
        check("mode_state", state, 0);
        check("mode_q_empty", exp_q.size(), 0);
        check("mode_cnt", cycle_count, 34);

        // halt during continuous run is terminal
        div_sel = 8'd0; run_en = 1'b1;
        wait_state(2'd1, e);
        for (int i = 1; i <= 5; i++) exp_q.push_back(e + i);
        tick(5);
        halt = 1'b1;
        tick(1);
        check("halt_state", state, 2);
        check("halt_ce", cpu_ce, 0);
        halt = 1'b0;
        step_btn = 1'b1; tick(12);
        step_btn = 1'b0; tick(8);
        run_en = 1'b0; tick(5);
        run_en = 1'b1; tick(5);
        check("halt_state_hold", state, 2);
        check("halt_cnt", cycle_count, 39);
        check("halt_q_empty", exp_q.size(), 0);
        check("sat_cnt_final", sat_count, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
